// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator that walks the TAP from Run-Test/Idle through one IR/DR scan and back.
//
// Optional feature macro: JTAG_HOST_RUNTEST_EN adds cmd_idle and extra Run-Test/Idle TCKs after each scan.
//
// Ports:
//   clk, rst               system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle in Run-Test/Idle)
//   cmd_ir                 1 = IR scan, 0 = DR scan
//   cmd_len, cmd_data      scan length (clamped to MAX_LEN) and TDI bits, bit 0 first
//   cmd_idle               (JTAG_HOST_RUNTEST_EN only) extra Run-Test/Idle TCKs after the scan
//   rsp_valid, rsp_data    one-clk completion pulse and captured TDO bits (held until next pulse)
//   TCK, TMS, TDI, TDO     JTAG pins
module jtag_host #(
    parameter int MAX_LEN = 32,
    parameter int DIV     = 2,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
`ifdef JTAG_HOST_RUNTEST_EN
    ,
    input  logic [7:0]         cmd_idle
`endif
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW = (LW > 8) ? LW : 8;

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RUN, RSP} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [NW-1:0]      n_q;
    logic [LW-1:0]      len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic               ir_q;
    logic [NW-1:0]      nxt_d;
    logic [NW-1:0]      n2_d;
    logic [LW-1:0]      len_d;
    logic               phase_end_d;
    logic               run_more_d;
    logic               run_last_d;
    logic               done_d;

    assign nxt_d       = n_q + NW'(1);
    assign n2_d        = n_q + NW'(2);
    assign len_d       = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
    assign phase_end_d = cnt_q == CW'(DIV - 1);

`ifdef JTAG_HOST_RUNTEST_EN
    logic [7:0] idle_q;
    assign run_more_d = idle_q != 8'd0;
    assign run_last_d = nxt_d == NW'(idle_q);
`else
    assign run_more_d = 1'b0;
    assign run_last_d = 1'b0;
`endif

    // Scan ends on the falling edge of the last Update/Run-Test TCK.
    assign done_d = ((state_q == POST) && (n_q == NW'(1)) && !run_more_d) ||
                    ((state_q == RUN) && run_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            n_q       <= '0;
            len_q     <= '0;
            data_q    <= '0;
            cap_q     <= '0;
            ir_q      <= 1'b0;
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef JTAG_HOST_RUNTEST_EN
            idle_q    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        len_q     <= len_d;
                        data_q    <= cmd_data;
                        ir_q      <= cmd_ir;
                        cap_q     <= '0;
                        n_q       <= '0;
                        cnt_q     <= '0;
`ifdef JTAG_HOST_RUNTEST_EN
                        idle_q    <= cmd_idle;
`endif
                        if (len_d == '0) begin
                            state_q   <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state_q <= PRE;
                            TMS     <= 1'b1;
                        end
                    end
                end
                RSP: begin
                    state_q   <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    if (!phase_end_d) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        TCK   <= ~TCK;
                        if (!TCK) begin
                            // TDO is captured on the clk that raises TCK; first bit ends up at the bottom.
                            if (state_q == SHIFT) cap_q <= MAX_LEN'({TDO, cap_q} >> 1);
                        end else if (done_d) begin
                            state_q   <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= cap_q >> (LW'(MAX_LEN) - len_q);
                            TMS       <= 1'b0;
                        end else begin
                            // Falling edge: choose TMS/TDI for the next TCK.
                            case (state_q)
                                INIT: begin
                                    if (nxt_d == NW'(6)) begin
                                        state_q   <= IDLE;
                                        cmd_ready <= 1'b1;
                                        n_q       <= '0;
                                    end else begin
                                        n_q <= nxt_d;
                                        TMS <= nxt_d != NW'(5);
                                    end
                                end
                                PRE: begin
                                    if (nxt_d == (ir_q ? NW'(4) : NW'(3))) begin
                                        state_q <= SHIFT;
                                        n_q     <= '0;
                                        TMS     <= len_q == LW'(1);
                                        TDI     <= data_q[0];
                                        data_q  <= data_q >> 1;
                                    end else begin
                                        n_q <= nxt_d;
                                        TMS <= nxt_d < (ir_q ? NW'(2) : NW'(1));
                                    end
                                end
                                SHIFT: begin
                                    if (nxt_d == NW'(len_q)) begin
                                        state_q <= POST;
                                        n_q     <= '0;
                                        TMS     <= 1'b1;
                                        TDI     <= 1'b0;
                                    end else begin
                                        n_q    <= nxt_d;
                                        TMS    <= n2_d == NW'(len_q);
                                        TDI    <= data_q[0];
                                        data_q <= data_q >> 1;
                                    end
                                end
                                POST: begin
                                    TMS <= 1'b0;
                                    if (n_q == '0) begin
                                        n_q <= NW'(1);
                                    end else begin
                                        state_q <= RUN;
                                        n_q     <= '0;
                                    end
                                end
                                default: n_q <= nxt_d;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: randomized self-checking bench for jtag_host against a TCK-level sequence model.
module tb_jtag_host;
    localparam int ML = 32;
    localparam int DV = 2;

    logic        clk = 0, rst = 1, cmd_valid = 0, cmd_ir = 0;
    logic [5:0]  cmd_len = 0;
    logic [31:0] cmd_data = 0;
    logic        cmd_ready, rsp_valid, TCK, TMS, TDI, TDO;
    logic [31:0] rsp_data;
    logic        loopback = 0, tdo_r = 0;
`ifdef JTAG_HOST_RUNTEST_EN
    logic [7:0]  cmd_idle = 0;
`endif

    int checks = 0, failures = 0, rsp_pulses = 0, glitches = 0;
    bit tms_q[$], tdi_q[$], tdo_q[$];
    logic pt = 0, pm = 0, pd = 0;

    jtag_host #(.MAX_LEN(ML), .DIV(DV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
`ifdef JTAG_HOST_RUNTEST_EN
        , .cmd_idle(cmd_idle)
`endif
    );

    assign TDO = loopback ? TDI : tdo_r;

    always #5 clk = ~clk;

    always @(posedge TCK) begin
        tms_q.push_back(TMS);
        tdi_q.push_back(TDI);
        tdo_q.push_back(TDO);
    end

    always @(negedge TCK) tdo_r = 1'($urandom);

    always @(posedge clk) if (rsp_valid) rsp_pulses++;

    // TMS/TDI must stay put while TCK is high.
    always @(posedge clk) begin
        #1;
        if (pt && TCK && (TMS !== pm || TDI !== pd)) glitches++;
        pt = TCK; pm = TMS; pd = TDI;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_q();
        tms_q.delete(); tdi_q.delete(); tdo_q.delete();
    endtask

    // Release reset just after an edge and expect 5 TMS=1 TCKs, 1 TMS=0 TCK, ready at clk 24.
    task automatic release_and_init(input string tag);
        int k = 0;
        logic [5:0] seq = 0;
        clear_q();
        rst = 0;
        while (!cmd_ready && k < 200) begin tick(); k++; end
        checks++;
        if (k !== 24) begin failures++; $display("FAIL %s_ready_clk: got %0d expected 24", tag, k); end
        checks++;
        if (tms_q.size() !== 6) begin failures++; $display("FAIL %s_tck_count: got %0d expected 6", tag, tms_q.size()); end
        for (int i = 0; i < tms_q.size() && i < 6; i++) seq[5-i] = tms_q[i];
        checks++;
        if (seq !== 6'b111110) begin failures++; $display("FAIL %s_tms_seq: got %b expected 111110", tag, seq); end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        checks++;
        if ({TCK, TMS, TDI, cmd_ready, rsp_valid} !== 5'b01000) begin
            failures++; $display("FAIL reset_outputs: got %b expected 01000", {TCK, TMS, TDI, cmd_ready, rsp_valid});
        end
        checks++;
        if (rsp_data !== 0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        release_and_init("init");
    endtask

    // One scan, compared against the TCK-level sequence the TAP walk dictates.
    task automatic scan(input bit ir, input int len, input logic [31:0] data, input int idle, output logic [31:0] got);
        int L   = (len > ML) ? ML : len;
        int pre = ir ? 4 : 3;
        int n   = (L == 0) ? 0 : pre + L + 2 + idle;
        int k   = 0;
        int bad = -1;
        bit et[$], ed[$];
        logic [31:0] exp_rsp = 0;
        while (!cmd_ready && k < 200) begin tick(); k++; end
        clear_q();
        @(negedge clk);
        cmd_valid = 1; cmd_ir = ir; cmd_len = 6'(len); cmd_data = data;
`ifdef JTAG_HOST_RUNTEST_EN
        cmd_idle = 8'(idle);
`endif
        tick();
        cmd_valid = 0;
        checks++;
        if (cmd_ready !== 0) begin failures++; $display("FAIL ready_drop: got %b expected 0", cmd_ready); end
        k = 0;
        while (rsp_valid !== 1 && k < 5000) begin tick(); k++; end
        checks++;
        if (k !== n * 2 * DV) begin failures++; $display("FAIL rsp_latency len=%0d: got %0d expected %0d", len, k, n * 2 * DV); end
        checks++;
        if (tms_q.size() !== n) begin failures++; $display("FAIL tck_count len=%0d: got %0d expected %0d", len, tms_q.size(), n); end
        if (L > 0) begin
            et.push_back(1); if (ir) et.push_back(1); et.push_back(0); et.push_back(0);
            repeat (pre) ed.push_back(0);
            for (int i = 0; i < L; i++) begin et.push_back(i == L - 1); ed.push_back(data[i]); end
            et.push_back(1); et.push_back(0); ed.push_back(0); ed.push_back(0);
            repeat (idle) begin et.push_back(0); ed.push_back(0); end
            for (int i = 0; i < L && pre + i < tdo_q.size(); i++) exp_rsp[i] = tdo_q[pre + i];
        end
        for (int i = 0; i < et.size() && i < tms_q.size(); i++)
            if (bad < 0 && (tms_q[i] !== et[i] || tdi_q[i] !== ed[i])) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL pin_seq len=%0d ir=%0d: tck %0d got tms/tdi %b%b expected %b%b", len, ir, bad, tms_q[bad], tdi_q[bad], et[bad], ed[bad]);
        end
        checks++;
        if (rsp_data !== exp_rsp) begin failures++; $display("FAIL rsp_data len=%0d: got %h expected %h", len, rsp_data, exp_rsp); end
        got = rsp_data;
        tick();
        checks++;
        if ({rsp_valid, cmd_ready, TCK, TDI} !== 4'b0100) begin
            failures++; $display("FAIL rsp_end: got valid/ready/tck/tdi %b expected 0100", {rsp_valid, cmd_ready, TCK, TDI});
        end
    endtask

    task automatic test_dr_loopback();
        logic [31:0] got;
        loopback = 1;
        scan(0, 8, 32'hA5, 0, got);
        loopback = 0;
        checks++;
        if (got !== 32'hA5) begin failures++; $display("FAIL loopback_a5: got %h expected a5", got); end
    endtask

    task automatic test_ir();
        logic [31:0] got;
        logic [7:0] seq = 0;
        scan(1, 2, 32'h2, 0, got);
        for (int i = 0; i < 8 && i < tms_q.size(); i++) seq[7-i] = tms_q[i];
        checks++;
        if (seq !== 8'b11000110) begin failures++; $display("FAIL ir_tms: got %b expected 11000110", seq); end
        checks++;
        if (tdi_q.size() < 6 || {tdi_q[5], tdi_q[4]} !== 2'b10) begin
            failures++; $display("FAIL ir_inst: shifted bits wrong, tck count %0d", tdi_q.size());
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] got;
        scan(0, 7, 32'h7F, 0, got);
        scan(0, 0, 32'hFFFF_FFFF, 0, got);
        checks++;
        if (got !== 0) begin failures++; $display("FAIL zero_len_data: got %h expected 0", got); end
    endtask

    task automatic test_clamp_and_hold();
        logic [31:0] got;
        loopback = 1;
        scan(1, 45, 32'hDEAD_BEEF, 0, got);
        loopback = 0;
        checks++;
        if (got !== 32'hDEAD_BEEF) begin failures++; $display("FAIL clamp_data: got %h expected deadbeef", got); end
        repeat (10) tick();
        checks++;
        if (rsp_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rsp_hold: got %h expected deadbeef", rsp_data); end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int t = 0; t < 20; t++) begin
            loopback = 1'($urandom);
            scan(1'($urandom), $urandom_range(0, 40), $urandom, 0, got);
        end
        loopback = 0;
    endtask

    task automatic test_reset_mid_scan();
        int k = 0;
        int p0;
        while (!cmd_ready && k < 200) begin tick(); k++; end
        clear_q();
        @(negedge clk);
        cmd_valid = 1; cmd_ir = 0; cmd_len = 8; cmd_data = 32'hFF;
        tick();
        cmd_valid = 0;
        k = 0;
        while (tms_q.size() < 7 && k < 500) begin tick(); k++; end
        p0 = rsp_pulses;
        rst = 1;
        #1;
        checks++;
        if ({TCK, TMS, TDI, cmd_ready, rsp_valid} !== 5'b01000) begin
            failures++; $display("FAIL midrst_outputs: got %b expected 01000", {TCK, TMS, TDI, cmd_ready, rsp_valid});
        end
        repeat (3) tick();
        release_and_init("midrst");
        checks++;
        if (rsp_pulses !== p0) begin failures++; $display("FAIL midrst_rsp: got %0d pulses expected %0d", rsp_pulses, p0); end
    endtask

`ifdef JTAG_HOST_RUNTEST_EN
    task automatic test_runtest();
        logic [31:0] got;
        scan(0, 4, 32'h9, 3, got);
        checks++;
        if (tms_q.size() !== 12) begin failures++; $display("FAIL runtest_tck: got %0d expected 12", tms_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_dr_loopback();
        test_ir();
        test_zero_len();
        test_clamp_and_hold();
        test_random();
`ifdef JTAG_HOST_RUNTEST_EN
        test_runtest();
`endif
        test_reset_mid_scan();
        checks++;
        if (glitches !== 0) begin failures++; $display("FAIL tms_tdi_stable: got %0d changes while TCK high expected 0", glitches); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
